hovalaag_run_ctrl: RTL

Parametrised run controller for the Hovalaag CPU harness. It replaces the toggled divided CPU clock with a single-cycle clock enable (`cpu_ce`) on the board clock. It supports:
- debounced single-step;
- free-run at a selectable rate;
- an address breakpoint that halts the CPU before the matching instruction executes;
- a wrapping count of executed steps.

The top level uses `cpu_ce` as the CPU enable and as the input-FIFO advance qualifier, which replaces the edge-detect pulse.

---
 rtl/hovalaag_run_ctrl_if.sv | 28 ++
 rtl/hovalaag_run_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/hovalaag_run_ctrl_if.sv
// Control/status bundle between the Hovalaag harness and its run controller.
// The harness (master) drives the run controls and the CPU's PC; the controller answers with the enable and status.
interface hovalaag_run_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int RATE_W = 2,
    parameter int CNT_W  = 16
);
    logic              run;
    logic [RATE_W-1:0] rate_sel;
    logic              step_btn;
    logic              bp_en;
    logic [ADDR_W-1:0] bp_addr;
    logic [ADDR_W-1:0] pc;
    logic              cpu_ce;
    logic              running;
    logic              bp_hit;
    logic [CNT_W-1:0]  step_count;

    modport master (
        output run, rate_sel, step_btn, bp_en, bp_addr, pc,
        input  cpu_ce, running, bp_hit, step_count
    );

    modport slave (
        input  run, rate_sel, step_btn, bp_en, bp_addr, pc,
        output cpu_ce, running, bp_hit, step_count
    );
endinterface

// File: rtl/hovalaag_run_ctrl.sv
// Hovalaag run controller: produces a one-cycle CPU clock enable on the board clock
// from debounced single-step, rate-divided free-run and an address breakpoint.
//
// state    | meaning
// ST_STOP  | CPU held; each debounced step press gives one cpu_ce
// ST_RUN   | free-run, one cpu_ce per divider period
// ST_BREAK | halted before the instruction at bp_addr; a step press executes it and resumes
module hovalaag_run_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int DIV_W      = 24,
    parameter int RATE_W     = 2,
    parameter int RATE_SHIFT = 3,
    parameter int DEBOUNCE   = 65535,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    hovalaag_run_ctrl_if.slave    bus
);

    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_ONES = '1;

    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_BREAK = 2'd2;

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic [DB_W-1:0]   deb_cnt_q, deb_cnt_d;
    logic              deb_lvl_q, deb_lvl_d;
    logic              step_evt_q, step_evt_d;

    logic [1:0]        state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              armed_q, armed_d;
    logic              cpu_ce_q, cpu_ce_d;
    logic              running_q, running_d;
    logic              bp_hit_q, bp_hit_d;
    logic [CNT_W-1:0]  step_count_q, step_count_d;

    logic [RATE_W-1:0] rate_w;
    logic [ADDR_W-1:0] pc_w, bp_addr_w;
    logic [31:0]       shift_amt;
    logic [DIV_W-1:0]  div_term;
    logic              bp_match;

    assign rate_w    = bus.rate_sel;
    assign pc_w      = bus.pc;
    assign bp_addr_w = bus.bp_addr;

    always_comb begin
        sync1_d    = bus.step_btn;
        sync2_d    = sync1_q;
        deb_cnt_d  = '0;
        deb_lvl_d  = deb_lvl_q;
        if (sync2_q != deb_lvl_q) begin
            if (deb_cnt_q == DB_W'(DEBOUNCE - 1)) begin
                deb_lvl_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
        step_evt_d = deb_lvl_d & ~deb_lvl_q;
    end

    // Terminal count is P-1 = all-ones shifted down; a zero result means P would drop below 2.
    always_comb begin
        shift_amt = RATE_SHIFT * 32'(rate_w);
        div_term  = DIV_ONES >> shift_amt;
        if (div_term == '0) begin
            div_term = DIV_W'(1);
        end
    end

    assign bp_match = bus.bp_en && armed_q && (pc_w == bp_addr_w);

    always_comb begin
        state_d  = state_q;
        div_d    = '0;
        armed_d  = armed_q;
        cpu_ce_d = 1'b0;
        case (state_q)
            ST_STOP: begin
                if (bus.run) begin
                    state_d = ST_RUN;
                    armed_d = 1'b0;
                end else if (step_evt_q) begin
                    cpu_ce_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (!bus.run) begin
                    state_d = ST_STOP;
                end else if (div_q >= div_term) begin
                    if (bp_match) begin
                        state_d = ST_BREAK;
                    end else begin
                        cpu_ce_d = 1'b1;
                        armed_d  = 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_BREAK: begin
                if (!bus.run) begin
                    state_d = ST_STOP;
                end else if (step_evt_q) begin
                    cpu_ce_d = 1'b1;
                    armed_d  = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            default: state_d = ST_STOP;
        endcase
        running_d    = (state_d == ST_RUN);
        bp_hit_d     = (state_d == ST_BREAK);
        step_count_d = step_count_q + CNT_W'(cpu_ce_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            deb_cnt_q    <= '0;
            deb_lvl_q    <= 1'b0;
            step_evt_q   <= 1'b0;
            state_q      <= ST_STOP;
            div_q        <= '0;
            armed_q      <= 1'b0;
            cpu_ce_q     <= 1'b0;
            running_q    <= 1'b0;
            bp_hit_q     <= 1'b0;
            step_count_q <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            deb_cnt_q    <= deb_cnt_d;
            deb_lvl_q    <= deb_lvl_d;
            step_evt_q   <= step_evt_d;
            state_q      <= state_d;
            div_q        <= div_d;
            armed_q      <= armed_d;
            cpu_ce_q     <= cpu_ce_d;
            running_q    <= running_d;
            bp_hit_q     <= bp_hit_d;
            step_count_q <= step_count_d;
        end
    end

    assign bus.cpu_ce     = cpu_ce_q;
    assign bus.running    = running_q;
    assign bus.bp_hit     = bp_hit_q;
    assign bus.step_count = step_count_q;

endmodule
